// File: rtl/register_dump_tx.sv
// register_dump_tx
// Streams a frame to a byte-wide UART transmitter: one header byte, then every
// register of the bank, least-significant byte first. The register is picked with
// reg_sel, and the bank returns its value on reg_val in the same cycle.
// The register is captured only in LOAD. Each byte is launched with a one-cycle
// tx_start pulse, and the next byte waits for the transmitter's tx_done_tick.

module register_dump_tx #(
   parameter int unsigned B      = 32,
   parameter int unsigned W      = 5,
   parameter int unsigned NREG   = 32,
   parameter logic [7:0]  HEADER = 8'hA5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [B-1:0] reg_val,
   input  logic         tx_done_tick,
   output logic [W-1:0] reg_sel,
   output logic [7:0]   tx_data,
   output logic         tx_start,
   output logic         busy,
   output logic         done_tick
);

   localparam int unsigned   NBYTES    = B / 8;
   localparam int unsigned   CW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
   localparam logic [W-1:0]  LAST_IDX  = W'(NREG - 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      HDR_WAIT,
      LOAD,
      SEND,
      WAIT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  idx_q, idx_d;
   logic [W-1:0]  reg_sel_q, reg_sel_d;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;
   logic [B-1:0]  shreg_q, shreg_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;
   logic          busy_q, busy_d;
   logic          done_tick_q, done_tick_d;

   // Next-state logic. The one-cycle pulses default low. Every other register holds its value.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      reg_sel_d   = reg_sel_q;
      byte_cnt_d  = byte_cnt_q;
      shreg_d     = shreg_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      busy_d      = busy_q;
      done_tick_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d      = '0;
               reg_sel_d  = '0;
               tx_data_d  = HEADER;
               tx_start_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = HDR;
            end
         end
         HDR: begin
            state_d = HDR_WAIT;
         end
         HDR_WAIT: begin
            if (tx_done_tick) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            shreg_d    = reg_val;
            byte_cnt_d = '0;
            state_d    = SEND;
         end
         SEND: begin
            tx_data_d  = shreg_q[7:0];
            tx_start_d = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            if (tx_done_tick) begin
               if (byte_cnt_q != LAST_BYTE) begin
                  shreg_d    = shreg_q >> 8;
                  byte_cnt_d = byte_cnt_q + CW'(1);
                  state_d    = SEND;
               end else if (idx_q != LAST_IDX) begin
                  idx_d     = idx_q + W'(1);
                  reg_sel_d = idx_q + W'(1);
                  state_d   = LOAD;
               end else begin
                  // Raise done_tick here so that it is high during the DONE cycle itself.
                  done_tick_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs. An asynchronous reset aborts any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         reg_sel_q   <= '0;
         byte_cnt_q  <= '0;
         shreg_q     <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_tick_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         reg_sel_q   <= reg_sel_d;
         byte_cnt_q  <= byte_cnt_d;
         shreg_q     <= shreg_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         busy_q      <= busy_d;
         done_tick_q <= done_tick_d;
      end
   end

   assign reg_sel   = reg_sel_q;
   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign busy      = busy_q;
   assign done_tick = done_tick_q;

endmodule

// File: tb/tb_register_dump_tx.sv
// Testbench for register_dump_tx. The register bank is an array indexed by reg_sel.
// A UART model answers every tx_start with a tx_done_tick after a random delay.
// Each frame's expected byte stream is built as a queue from the register contents.
module tb_register_dump_tx;

   localparam int unsigned B         = 32;
   localparam int unsigned W         = 5;
   localparam int unsigned NREG      = 32;
   localparam int unsigned FRAME_LEN = 1 + NREG * (B / 8);

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [B-1:0] reg_val;
   logic         tx_done_tick;
   logic [W-1:0] reg_sel;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic         busy;
   logic         done_tick;

   logic [B-1:0] regs [NREG];
   logic         uart_tick;
   logic         spur_tick;
   logic         idle_spur;
   logic         spur_en;
   int unsigned  ucnt;

   int           errors = 0;
   int           checks = 0;

   logic [7:0]   exp_q [$];
   logic [7:0]   rx [FRAME_LEN + 8];
   int           rx_n;
   int           done_cnt;
   logic         pending;
   logic [7:0]   last_byte;

   register_dump_tx #(
      .B(B),
      .W(W),
      .NREG(NREG),
      .HEADER(8'hA5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .reg_val(reg_val),
      .tx_done_tick(tx_done_tick),
      .reg_sel(reg_sel),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .busy(busy),
      .done_tick(done_tick)
   );

   always #5 clk = ~clk;

   assign reg_val      = regs[reg_sel];
   assign tx_done_tick = uart_tick | spur_tick | idle_spur;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected frame: the header, then each register least-significant byte first.
   task automatic build_frame();
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int k = 0; k < int'(NREG); k++) begin
         for (int b = 0; b < int'(B / 8); b++) begin
            exp_q.push_back(8'((regs[k] >> (8 * b)) & 32'hFF));
         end
      end
   endtask

   task automatic randomize_regs();
      for (int k = 0; k < int'(NREG); k++) regs[k] = $urandom;
   endtask

   task automatic check_reset_outputs(input string name);
      check_eq(name, 32'({reg_sel, tx_data, tx_start, busy, done_tick}), 32'd0);
   endtask

   // UART model: answers each tx_start with a tick 1..4 cycles later.
   // While spur_en is set, it also adds a spurious tick in the cycle after each real tick,
   // when the DUT is in LOAD or SEND.
   initial begin
      uart_tick = 1'b0;
      spur_tick = 1'b0;
      ucnt      = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            ucnt      = 0;
            uart_tick = 1'b0;
            spur_tick = 1'b0;
         end else begin
            spur_tick = uart_tick & spur_en;
            uart_tick = 1'b0;
            if (ucnt > 0) begin
               ucnt--;
               if (ucnt == 0) uart_tick = 1'b1;
            end else if (tx_start) begin
               ucnt = $urandom_range(1, 4);
            end
         end
      end
   end

   // Per-cycle comparison of the DUT outputs against the expected byte queue.
   initial begin
      logic [7:0] e;
      pending   = 1'b0;
      rx_n      = 0;
      done_cnt  = 0;
      last_byte = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            pending = 1'b0;
         end else begin
            if (tx_start) begin
               check_eq("no_double_start", 32'(pending), 32'd0);
               check_eq("busy_while_sending", 32'(busy), 32'd1);
               check_eq("byte_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check_eq("tx_byte", 32'(tx_data), 32'(e));
               end
               if (rx_n < int'(FRAME_LEN + 8)) rx[rx_n] = tx_data;
               rx_n++;
               pending   = 1'b1;
               last_byte = tx_data;
            end else if (pending) begin
               check_eq("tx_data_held", 32'(tx_data), 32'(last_byte));
            end
            if (uart_tick) pending = 1'b0;
            if (done_tick) begin
               done_cnt++;
               check_eq("done_after_all_bytes", 32'(exp_q.size()), 32'd0);
               check_eq("done_nothing_pending", 32'(pending), 32'd0);
            end
         end
      end
   end

   // Runs one frame. At byte inject_at, start is pulsed again while the DUT is busy.
   // At byte abort_at, reset is asserted mid-cycle and the frame is abandoned.
   task automatic run_frame(input int inject_at, input int abort_at);
      bit injected;
      int budget;
      injected = 1'b0;
      build_frame();
      rx_n     = 0;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      budget = 0;
      while (done_cnt == 0 && budget < 6000) begin
         @(negedge clk);
         budget++;
         if (inject_at >= 0 && !injected && rx_n >= inject_at) begin
            start    = 1'b1;
            injected = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (abort_at >= 0 && rx_n >= abort_at) begin
            @(posedge clk);
            #3 reset = 1'b1;
            #1 check_reset_outputs("reset_mid_frame_outputs");
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            return;
         end
      end
      start = 1'b0;
      check_eq("frame_completes", 32'(done_cnt != 0), 32'd1);
      repeat (2) @(negedge clk);
      check_eq("busy_low_after_done", 32'(busy), 32'd0);
      check_eq("single_done_tick", 32'(done_cnt), 32'd1);
      check_eq("frame_length", 32'(rx_n), 32'(FRAME_LEN));
      check_eq("reg_sel_parks_last", 32'(reg_sel), 32'(NREG - 1));
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      idle_spur = 1'b0;
      spur_en   = 1'b0;
      for (int k = 0; k < int'(NREG); k++) regs[k] = '0;
      #2 check_reset_outputs("reset_outputs");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Full dump with known register contents.
      for (int k = 0; k < int'(NREG); k++) regs[k] = 32'h1000_0000 + 32'(k);
      run_frame(-1, -1);
      check_eq("t2_byte0_hdr", 32'(rx[0]), 32'h A5);
      check_eq("t2_byte1", 32'(rx[1]), 32'h00);
      check_eq("t2_byte4", 32'(rx[4]), 32'h10);
      check_eq("t2_byte5", 32'(rx[5]), 32'h01);
      check_eq("t2_byte125", 32'(rx[125]), 32'h1F);
      check_eq("t2_byte128", 32'(rx[128]), 32'h10);

      // Byte order within a register.
      randomize_regs();
      regs[0] = 32'hDEAD_BEEF;
      run_frame(-1, -1);
      check_eq("t3_byte2", 32'(rx[1]), 32'hEF);
      check_eq("t3_byte3", 32'(rx[2]), 32'hBE);
      check_eq("t3_byte4", 32'(rx[3]), 32'hAD);
      check_eq("t3_byte5", 32'(rx[4]), 32'hDE);

      // A start pulse during a frame is ignored.
      randomize_regs();
      run_frame(40, -1);

      // A spurious tick in IDLE starts nothing.
      @(negedge clk);
      idle_spur = 1'b1;
      @(negedge clk);
      idle_spur = 1'b0;
      check_eq("idle_spur_no_busy", 32'(busy), 32'd0);
      check_eq("idle_spur_no_start", 32'(tx_start), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("idle_spur_still_idle", 32'(busy), 32'd0);

      // Spurious ticks in LOAD/SEND throughout a frame.
      randomize_regs();
      spur_en = 1'b1;
      run_frame(-1, -1);
      spur_en = 1'b0;

      // Reset after byte 60, then a fresh frame.
      randomize_regs();
      run_frame(-1, 60);
      check_eq("after_abort_idle", 32'(busy), 32'd0);
      randomize_regs();
      regs[0] = 32'h7654_3210;
      run_frame(-1, -1);
      check_eq("t6_hdr", 32'(rx[0]), 32'hA5);
      check_eq("t6_reg0_b0", 32'(rx[1]), 32'h10);
      check_eq("t6_reg0_b1", 32'(rx[2]), 32'h32);
      check_eq("t6_reg0_b3", 32'(rx[4]), 32'h76);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
      $fatal(1, "timeout");
   end

endmodule
